// File: rtl/mio_uart_tx_if.sv
// Bus-side signal bundle for the UART transmitter: write strobe/data and
// overflow clear in, serial line and status out.
interface mio_uart_tx_if;
    logic        EN;
    logic [31:0] P_Data;
    logic        clr_ovf;
    logic        txd;
    logic        busy;
    logic [31:0] status_out;

    modport master (
        output EN,
        output P_Data,
        output clr_ovf,
        input  txd,
        input  busy,
        input  status_out
    );

    modport slave (
        input  EN,
        input  P_Data,
        input  clr_ovf,
        output txd,
        output busy,
        output status_out
    );
endinterface

// File: rtl/mio_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO with a sticky overflow flag.
// One IDLE cycle separates queued frames: frame period is 10*CLK_DIV+1 clocks.
module mio_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    mio_uart_tx_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;

    state_t            state_reg;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [BAUD_W-1:0] baud_cnt_next;
    logic [2:0]        bit_idx_reg;
    logic [2:0]        bit_idx_next;
    logic [2:0]        bit_idx_inc;
    logic [7:0]        shift_reg;
    logic              txd_reg;
    logic              txd_next;
    logic              busy_reg;
    logic              busy_next;

    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic              ovf_set;
    logic              baud_last;
    logic              unused_data_hi;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_FULL);

    // A pop frees a slot in the same cycle, so a write to a full FIFO is
    // still accepted when the transmitter takes the head byte.
    assign pop     = (state_reg == ST_IDLE) && !fifo_empty;
    assign push    = bus.EN && (!fifo_full || pop);
    assign ovf_set = bus.EN && fifo_full && !pop;

    assign baud_last      = (baud_cnt_reg == BAUD_LAST);
    assign bit_idx_inc    = bit_idx_reg + 3'd1;
    assign unused_data_hi = ^bus.P_Data[31:8];

    // Storage and the registered read into the shift register carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.P_Data[7:0];
        end
        if (pop) begin
            shift_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            // A new overflow wins over a simultaneous clear.
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // txd/busy are computed for the next state so the line is a flop output.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        txd_next      = txd_reg;
        busy_next     = busy_reg;
        case (state_reg)
            ST_IDLE: begin
                txd_next      = 1'b1;
                busy_next     = 1'b0;
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                if (pop) begin
                    state_next = ST_START;
                    txd_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = ST_DATA;
                    txd_next      = shift_reg[0];
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        txd_next     = shift_reg[bit_idx_inc];
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    state_next    = ST_IDLE;
                    txd_next      = 1'b1;
                    busy_next     = 1'b0;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            txd_reg      <= txd_next;
            busy_reg     <= busy_next;
        end
    end

    assign bus.txd        = txd_reg;
    assign bus.busy       = busy_reg;
    assign bus.status_out = {27'b0, !fifo_empty, overflow_reg, fifo_full, fifo_empty, busy_reg};
endmodule

// File: doc/mio_uart_tx.md
MIO_UART_TX -- requirements
Module: mio_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, giving clk cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the transmit FIFO depth (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port EN, input, 1, bus write strobe for the data register.
REQ-006 SHALL have port P_Data, input, 32, bus write data; only bits [7:0] are used.
REQ-007 SHALL have port clr_ovf, input, 1, clears the overflow flag.
REQ-008 SHALL have port txd, output, 1, serial line, 8N1, LSB first, idle high.
REQ-009 SHALL have port busy, output, 1, high while a frame is on the line.
REQ-010 SHALL have port status_out, output, 32, bus-readable status word {27'b0, level_nz, overflow, full, empty, busy}, where level_nz is high when the FIFO is not empty.

Function
REQ-011 SHALL, on a clk edge with EN=1 and the FIFO not full, push P_Data[7:0] into the FIFO.
REQ-012 SHALL, on EN=1 with the FIFO full and no pop in the same cycle, drop the byte and set overflow; the FIFO contents SHALL be unchanged.
REQ-013 SHALL accept the write when EN=1, the FIFO is full and a pop occurs in the same cycle; overflow SHALL be unaffected.
REQ-014 SHALL keep overflow sticky until clr_ovf=1; if clr_ovf=1 and a new overflow occur in the same cycle, overflow SHALL be set.
REQ-015 SHALL derive full and empty from an occupancy count of 0..FIFO_DEPTH and SHALL use wrapping read and write pointers; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-016 SHALL implement the state machine IDLE, START, DATA, STOP, with a baud counter of 0..CLK_DIV-1 and a 3-bit bit index.
REQ-017 SHALL, in IDLE with the FIFO non-empty, pop the head byte into the shift register and enter START on the next edge; in IDLE, txd=1 and busy=0.
REQ-018 SHALL, in START, drive txd=0 for exactly CLK_DIV cycles, then enter DATA with bit index 0.
REQ-019 SHALL, in DATA, drive txd=shift[bit index] for CLK_DIV cycles per bit, bits 0..7, then enter STOP after bit 7.
REQ-020 SHALL, in STOP, drive txd=1 for CLK_DIV cycles, then return to IDLE.
REQ-021 SHALL make a frame 10*CLK_DIV cycles long, with busy=1 across START, DATA and STOP.
REQ-022 SHALL let back-to-back bytes be separated by exactly one IDLE cycle, i.e. a frame period of 10*CLK_DIV+1 cycles.
REQ-023 SHALL register txd, so that it changes only on clk edges and is glitch-free.
REQ-024 SHALL make a byte pushed while a frame is in progress wait in the FIFO and SHALL NOT disturb the current frame.
REQ-025 SHALL make status_out combinational from the registered flags, with no read side effects.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, txd=1, busy=0, FIFO empty, pointers and count 0, overflow 0, and baud counter and bit index 0.
REQ-027 SHALL, on rst asserted mid-frame, abort the frame, raise txd immediately without waiting for a clk edge, and discard all queued bytes.
REQ-028 SHALL give status_out the value 32'h0000_0002 after reset.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-029 SHALL cover: a single write of 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit, busy high for 40 cycles, status_out returning to 32'h0000_0002.
REQ-030 SHALL cover: writes of 0xA5 then 0x3C on consecutive cycles -> two frames whose start bits are 41 cycles apart, with the bit values matching LSB-first order.
REQ-031 SHALL cover: 6 writes on consecutive cycles while idle -> the first byte pops, 4 bytes are queued, the 6th is dropped, overflow=1, and status_out bits[3:1]=3'b110 (full=1, empty=0); a clr_ovf pulse then clears bit 3 only.
REQ-032 SHALL cover: FIFO full with EN=1 on the cycle IDLE pops -> the byte is accepted, overflow stays 0, and 5 frames are sent in total.
REQ-033 SHALL cover: rst asserted during bit 3 of a frame -> txd=1 asynchronously, no further frames are sent after release, and status_out=32'h0000_0002.
REQ-034 SHALL cover: clr_ovf and an overflowing write in the same cycle -> overflow reads 1 afterwards.
